control_cursa: RTL and testbench

- Run sequencer between the line-following steering logic and the two motor drivers (A right, B left).
- Arms a run on a start pulse and latches the circuit mode.
- Passes steering direction/duty through to the drivers under a soft-start duty ramp.
- Counts debounced finish-line crossings, stops the car at the mode's lap target, and stops it on a line-loss timeout.

---
 rtl/control_cursa.sv | 231 +++++++++++++++++++++++
 tb/tb_control_cursa.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/control_cursa.sv
// Run sequencer for the line follower: arms a run, ramps duty, counts laps,
// and stops the motors on lap target, line loss or abort.
module control_cursa #(
    parameter int DEBOUNCE     = 16,
    parameter int LAP_MIN      = 50000000,
    parameter int LOST_TIMEOUT = 25000000,
    parameter int RAMP_DIV     = 50000,
    parameter int RAMP_STEP    = 8,
    parameter int DC_MAX       = 2457
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  circuit,
    input  logic        senzor_1,
    input  logic        senzor_3,
    input  logic        senzor_5,
    input  logic [1:0]  dir_A_in,
    input  logic [1:0]  dir_B_in,
    input  logic [11:0] dc_A_in,
    input  logic [11:0] dc_B_in,
    output logic [1:0]  directie_driverA,
    output logic [1:0]  directie_driverB,
    output logic [11:0] factor_dc_driverA,
    output logic [11:0] factor_dc_driverB,
    output logic [7:0]  count_ture,
    output logic [2:0]  stare,
    output logic        cursa_gata,
    output logic        linie_pierduta
);

    localparam int DB_W   = $clog2(DEBOUNCE + 1);
    localparam int BL_W   = $clog2(LAP_MIN + 1);
    localparam int LS_W   = $clog2(LOST_TIMEOUT + 1);
    localparam int RP_W   = $clog2(RAMP_DIV + 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RUN  = 3'd1,
        S_DONE = 3'd2,
        S_LOST = 3'd3
    } state_t;

    state_t      r_state;
    logic [1:0]  r_mode;
    logic [3:0]  r_sync1;
    logic [3:0]  r_sync2;
    logic        r_start_q;
    logic [1:0]  r_dir_a;
    logic [1:0]  r_dir_b;
    logic [11:0] r_duty_a;
    logic [11:0] r_duty_b;
    logic [11:0] r_cap;
    logic [7:0]  r_laps;
    logic        r_gata;
    logic        r_lost;
    logic [DB_W-1:0] r_db_cnt;
    logic [BL_W-1:0] r_blank;
    logic [LS_W-1:0] r_lost_cnt;
    logic [RP_W-1:0] r_ramp_cnt;

    logic        w_start_ev;
    logic        w_s1;
    logic        w_s3;
    logic        w_s5;
    logic        w_db_hit;
    logic        w_accept;
    logic [7:0]  w_laps_next;
    logic        w_target_hit;
    logic        w_lost_hit;
    logic        w_ramp_tick;
    logic [12:0] w_cap_sum;
    logic [11:0] w_cap_next;
    logic [11:0] w_duty_a;
    logic [11:0] w_duty_b;

    // 2-FF synchronizers: {start, senzor_1, senzor_3, senzor_5}
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1   <= 4'b0;
            r_sync2   <= 4'b0;
            r_start_q <= 1'b0;
        end else begin
            r_sync1   <= {start, senzor_1, senzor_3, senzor_5};
            r_sync2   <= r_sync1;
            r_start_q <= r_sync2[3];
        end
    end

    assign w_start_ev = r_sync2[3] & ~r_start_q;
    assign w_s1       = r_sync2[2];
    assign w_s3       = r_sync2[1];
    assign w_s5       = r_sync2[0];

    assign w_db_hit    = w_s1 && w_s5 && (r_db_cnt == DB_W'(DEBOUNCE - 1));
    assign w_accept    = w_db_hit && (r_blank == '0);
    assign w_laps_next = (r_laps == 8'hFF) ? 8'hFF : r_laps + 8'd1;
    assign w_target_hit = w_accept &&
        (((r_mode == 2'b01) && (w_laps_next == 8'd1)) ||
         ((r_mode == 2'b10) && (w_laps_next == 8'd10)));
    assign w_lost_hit  = !w_s3 && (r_lost_cnt == LS_W'(LOST_TIMEOUT - 1));

    assign w_ramp_tick = (r_ramp_cnt == RP_W'(RAMP_DIV - 1));
    assign w_cap_sum   = {1'b0, r_cap} + 13'(RAMP_STEP);
    assign w_cap_next  = (w_cap_sum > 13'(DC_MAX)) ? 12'(DC_MAX)
                                                   : w_cap_sum[11:0];
    assign w_duty_a    = (dc_A_in < r_cap) ? dc_A_in : r_cap;
    assign w_duty_b    = (dc_B_in < r_cap) ? dc_B_in : r_cap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_mode     <= 2'b00;
            r_dir_a    <= 2'b00;
            r_dir_b    <= 2'b00;
            r_duty_a   <= 12'd0;
            r_duty_b   <= 12'd0;
            r_cap      <= 12'd0;
            r_laps     <= 8'd0;
            r_gata     <= 1'b0;
            r_lost     <= 1'b0;
            r_db_cnt   <= '0;
            r_blank    <= '0;
            r_lost_cnt <= '0;
            r_ramp_cnt <= '0;
        end else if (circuit == 2'b00) begin
            r_state    <= S_IDLE;
            r_dir_a    <= 2'b00;
            r_dir_b    <= 2'b00;
            r_duty_a   <= 12'd0;
            r_duty_b   <= 12'd0;
            r_cap      <= 12'd0;
            r_laps     <= 8'd0;
            r_gata     <= 1'b0;
            r_lost     <= 1'b0;
            r_db_cnt   <= '0;
            r_blank    <= '0;
            r_lost_cnt <= '0;
            r_ramp_cnt <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    r_dir_a  <= 2'b00;
                    r_dir_b  <= 2'b00;
                    r_duty_a <= 12'd0;
                    r_duty_b <= 12'd0;
                    if (w_start_ev) begin
                        r_mode     <= circuit;
                        r_laps     <= 8'd0;
                        r_cap      <= 12'd0;
                        r_db_cnt   <= '0;
                        r_blank    <= '0;
                        r_lost_cnt <= '0;
                        r_ramp_cnt <= '0;
                        r_state    <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_dir_a  <= dir_A_in;
                    r_dir_b  <= dir_B_in;
                    r_duty_a <= w_duty_a;
                    r_duty_b <= w_duty_b;
                    if (w_ramp_tick) begin
                        r_ramp_cnt <= '0;
                        r_cap      <= w_cap_next;
                    end else begin
                        r_ramp_cnt <= r_ramp_cnt + 1'b1;
                    end
                    // Counter parks at DEBOUNCE until the line is left
                    if (w_s1 && w_s5) begin
                        if (r_db_cnt != DB_W'(DEBOUNCE))
                            r_db_cnt <= r_db_cnt + 1'b1;
                    end else begin
                        r_db_cnt <= '0;
                    end
                    if (w_accept) begin
                        r_laps  <= w_laps_next;
                        r_blank <= BL_W'(LAP_MIN);
                    end else if (r_blank != '0) begin
                        r_blank <= r_blank - 1'b1;
                    end
                    if (!w_s3) begin
                        if (r_lost_cnt != LS_W'(LOST_TIMEOUT))
                            r_lost_cnt <= r_lost_cnt + 1'b1;
                    end else begin
                        r_lost_cnt <= '0;
                    end
                    if (w_target_hit || w_lost_hit) begin
                        r_dir_a  <= 2'b00;
                        r_dir_b  <= 2'b00;
                        r_duty_a <= 12'd0;
                        r_duty_b <= 12'd0;
                        r_cap    <= 12'd0;
                    end
                    if (w_target_hit) begin
                        r_state <= S_DONE;
                        r_gata  <= 1'b1;
                    end else if (w_lost_hit) begin
                        r_state <= S_LOST;
                        r_lost  <= 1'b1;
                    end
                end
                S_DONE, S_LOST: begin
                    r_dir_a  <= 2'b00;
                    r_dir_b  <= 2'b00;
                    r_duty_a <= 12'd0;
                    r_duty_b <= 12'd0;
                    r_cap    <= 12'd0;
                    if (w_start_ev) begin
                        r_state <= S_IDLE;
                        r_gata  <= 1'b0;
                        r_lost  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign directie_driverA  = r_dir_a;
    assign directie_driverB  = r_dir_b;
    assign factor_dc_driverA = r_duty_a;
    assign factor_dc_driverB = r_duty_b;
    assign count_ture        = r_laps;
    assign stare             = r_state;
    assign cursa_gata        = r_gata;
    assign linie_pierduta    = r_lost;

endmodule

// File: tb/tb_control_cursa.sv
// Directed bench for control_cursa with shortened timing parameters.
module tb_control_cursa;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  circuit;
    logic        senzor_1, senzor_3, senzor_5;
    logic [1:0]  dir_A_in, dir_B_in;
    logic [11:0] dc_A_in, dc_B_in;
    logic [1:0]  directie_driverA, directie_driverB;
    logic [11:0] factor_dc_driverA, factor_dc_driverB;
    logic [7:0]  count_ture;
    logic [2:0]  stare;
    logic        cursa_gata, linie_pierduta;

    int n_run  = 0;
    int n_fail = 0;

    control_cursa #(
        .DEBOUNCE(4), .LAP_MIN(20), .LOST_TIMEOUT(8),
        .RAMP_DIV(4), .RAMP_STEP(100), .DC_MAX(2457)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .circuit(circuit),
        .senzor_1(senzor_1), .senzor_3(senzor_3), .senzor_5(senzor_5),
        .dir_A_in(dir_A_in), .dir_B_in(dir_B_in),
        .dc_A_in(dc_A_in), .dc_B_in(dc_B_in),
        .directie_driverA(directie_driverA),
        .directie_driverB(directie_driverB),
        .factor_dc_driverA(factor_dc_driverA),
        .factor_dc_driverB(factor_dc_driverB),
        .count_ture(count_ture), .stare(stare),
        .cursa_gata(cursa_gata), .linie_pierduta(linie_pierduta)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  da, db;
        logic [11:0] ca, cb;
        logic [1:0]  eda, edb;
        logic [11:0] eya, eyb;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic arm(input logic [1:0] m);
        circuit = m;
        start   = 1'b1;
        step(2);
        chk("arm_wait", stare, 0);
        step(1);
        chk("arm_run", stare, 1);
        start = 1'b0;
    endtask

    task automatic start_pulse();
        start = 1'b1;
        step(3);
        start = 1'b0;
        step(2);
    endtask

    task automatic pulse(input int len, input int gap);
        senzor_1 = 1'b1;
        senzor_5 = 1'b1;
        step(len);
        senzor_1 = 1'b0;
        senzor_5 = 1'b0;
        step(gap);
    endtask

    initial begin
        int exp_d;
        vecs[0] = '{2'b01, 2'b01, 12'd1000, 12'd2000, 2'b01, 2'b01, 12'd1000, 12'd2000};
        vecs[1] = '{2'b10, 2'b01, 12'd4095, 12'd0,    2'b10, 2'b01, 12'd2457, 12'd0};
        vecs[2] = '{2'b00, 2'b10, 12'd2458, 12'd2456, 2'b00, 2'b10, 12'd2457, 12'd2456};
        vecs[3] = '{2'b01, 2'b10, 12'd2457, 12'd1,    2'b01, 2'b10, 12'd2457, 12'd1};
        vecs[4] = '{2'b10, 2'b10, 12'd3000, 12'd2457, 2'b10, 2'b10, 12'd2457, 12'd2457};
        vecs[5] = '{2'b00, 2'b00, 12'd0,    12'd0,    2'b00, 2'b00, 12'd0,    12'd0};

        rst_n = 1'b0; start = 1'b0; circuit = 2'b00;
        senzor_1 = 1'b0; senzor_3 = 1'b0; senzor_5 = 1'b0;
        dir_A_in = 2'b00; dir_B_in = 2'b00;
        dc_A_in = 12'd0; dc_B_in = 12'd0;
        step(3);
        chk("rst_stare", stare, 0);
        chk("rst_dir", {directie_driverA, directie_driverB}, 0);
        chk("rst_duty", {factor_dc_driverA, factor_dc_driverB}, 0);
        chk("rst_laps", count_ture, 0);
        chk("rst_flags", {cursa_gata, linie_pierduta}, 0);
        rst_n = 1'b1;
        step(2);

        start_pulse();
        chk("start_mode00_ignored", stare, 0);

        // Soft-start ramp
        senzor_3 = 1'b1;
        dir_A_in = 2'b01; dir_B_in = 2'b01;
        dc_A_in = 12'd2457; dc_B_in = 12'd2457;
        step(3);
        arm(2'b01);
        chk("dir_idle", directie_driverA, 0);
        step(1);
        chk("dir_latency", directie_driverA, 1);
        chk("ramp_k1", factor_dc_driverA, 0);
        for (int k = 2; k <= 110; k++) begin
            step(1);
            exp_d = 100 * ((k - 1) / 4);
            if (exp_d > 2457) exp_d = 2457;
            chk("ramp", factor_dc_driverA, exp_d);
        end

        // Pass-through with full cap
        for (int i = 0; i < 6; i++) begin
            dir_A_in = vecs[i].da; dir_B_in = vecs[i].db;
            dc_A_in  = vecs[i].ca; dc_B_in  = vecs[i].cb;
            step(1);
            chk("vec_dirA", directie_driverA, vecs[i].eda);
            chk("vec_dirB", directie_driverB, vecs[i].edb);
            chk("vec_dutyA", factor_dc_driverA, vecs[i].eya);
            chk("vec_dutyB", factor_dc_driverB, vecs[i].eyb);
        end

        circuit = 2'b00;
        step(1);
        chk("abort_ramp", stare, 0);

        // Mode 10: ten laps
        dir_A_in = 2'b01; dir_B_in = 2'b10;
        dc_A_in = 12'd500; dc_B_in = 12'd500;
        arm(2'b10);
        pulse(3, 27);
        chk("short_pulse", count_ture, 0);
        for (int i = 1; i <= 10; i++) begin
            pulse(6, 24);
            chk("lap_count", count_ture, i);
            if (i < 10) chk("lap_run", stare, 1);
        end
        chk("done_stare", stare, 2);
        chk("done_gata", cursa_gata, 1);
        chk("done_dir", {directie_driverA, directie_driverB}, 0);
        chk("done_duty", {factor_dc_driverA, factor_dc_driverB}, 0);
        start_pulse();
        chk("done_to_idle", stare, 0);
        chk("count_keep", count_ture, 10);
        chk("gata_clr", cursa_gata, 0);

        // Mode 01: single lap
        step(2);
        arm(2'b01);
        chk("m01_cleared", count_ture, 0);
        pulse(6, 10);
        chk("m01_done", stare, 2);
        chk("m01_laps", count_ture, 1);
        start_pulse();

        // Blanking then endurance
        step(2);
        arm(2'b11);
        pulse(6, 4);
        pulse(6, 4);
        chk("blank_once", count_ture, 1);
        step(20);
        pulse(6, 10);
        chk("blank_third", count_ture, 2);
        for (int i = 0; i < 300; i++) pulse(6, 24);
        chk("endur_sat", count_ture, 255);
        chk("endur_run", stare, 1);
        circuit = 2'b00;
        step(1);
        chk("abort_stare", stare, 0);
        chk("abort_laps", count_ture, 0);

        // Line loss
        step(2);
        arm(2'b11);
        step(4);
        senzor_3 = 1'b0;
        step(7);
        senzor_3 = 1'b1;
        step(4);
        chk("lost7_run", stare, 1);
        senzor_3 = 1'b0;
        step(9);
        chk("lost8_pre", stare, 1);
        step(1);
        chk("lost_stare", stare, 3);
        chk("lost_flag", linie_pierduta, 1);
        chk("lost_dir", {directie_driverA, directie_driverB}, 0);
        chk("lost_duty", {factor_dc_driverA, factor_dc_driverB}, 0);
        senzor_3 = 1'b1;
        start_pulse();
        chk("lost_to_idle", stare, 0);
        chk("lost_flag_clr", linie_pierduta, 0);

        // Asynchronous reset mid-run
        step(2);
        dc_A_in = 12'd2457;
        arm(2'b11);
        step(12);
        chk("pre_rst_dir", directie_driverA, 1);
        chk("pre_rst_duty", factor_dc_driverA, 200);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_stare", stare, 0);
        chk("arst_dir", {directie_driverA, directie_driverB}, 0);
        chk("arst_duty", {factor_dc_driverA, factor_dc_driverB}, 0);
        step(1);
        rst_n = 1'b1;
        step(1);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
